// File: rtl/axis_packet_router_if.sv
// AXI-Stream channel bundle used for the router's input and both outputs.
interface axis_packet_router_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_packet_router.sv
// Single-input, dual-output AXI-Stream packet router with a 2-entry input
// buffer, first-beat destination select and per-output packet counters.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | head beat is a packet start; dest taken from its SEL_BIT
// ST_ROUTE_A | mid-packet, dest locked to m0a
// ST_ROUTE_B | mid-packet, dest locked to m0b
module axis_packet_router #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_BIT    = 31,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 axis_aclk,
    input  logic                 axis_areset,
    axis_packet_router_if.slave  s0k_axis,
    axis_packet_router_if.master m0a_axis,
    axis_packet_router_if.master m0b_axis,
    output logic [CNT_WIDTH-1:0] pkt_cnt_a,
    output logic [CNT_WIDTH-1:0] pkt_cnt_b
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROUTE_A = 2'd1,
        ST_ROUTE_B = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH:0]    mem_q [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             count_q, count_d;
    logic                   rdy_q, rdy_d;
    logic [CNT_WIDTH-1:0]   cnt_a_q, cnt_a_d;
    logic [CNT_WIDTH-1:0]   cnt_b_q, cnt_b_d;

    logic [DATA_WIDTH:0]    head;
    logic                   head_valid;
    logic                   head_last;
    logic                   dest_b;
    logic                   push, pop;

    // Entry layout is {tlast, tdata}.
    assign head       = mem_q[rd_ptr_q];
    assign head_last  = head[DATA_WIDTH];
    assign head_valid = (count_q != 2'd0);
    assign dest_b     = (state_q == ST_ROUTE_B) ||
                        ((state_q == ST_IDLE) && head[SEL_BIT]);
    assign push       = s0k_axis.tvalid && rdy_q;
    assign pop        = head_valid && (dest_b ? m0b_axis.tready : m0a_axis.tready);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Ready is registered so the input never sees a path from output tready.
        rdy_d = (count_d != 2'd2);

        if (pop) begin
            if (head_last) begin
                state_d = ST_IDLE;
                if (dest_b) cnt_b_d = cnt_b_q + 1'b1;
                else        cnt_a_d = cnt_a_q + 1'b1;
            end else if (state_q == ST_IDLE) begin
                state_d = dest_b ? ST_ROUTE_B : ST_ROUTE_A;
            end
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            rdy_q    <= 1'b0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdy_q   <= rdy_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (push) mem_q[wr_ptr_q] <= {s0k_axis.tlast, s0k_axis.tdata};
    end

    assign s0k_axis.tready = rdy_q;

    assign m0a_axis.tdata  = head[DATA_WIDTH-1:0];
    assign m0a_axis.tlast  = head_last;
    assign m0a_axis.tvalid = head_valid && !dest_b;

    assign m0b_axis.tdata  = head[DATA_WIDTH-1:0];
    assign m0b_axis.tlast  = head_last;
    assign m0b_axis.tvalid = head_valid && dest_b;

    assign pkt_cnt_a = cnt_a_q;
    assign pkt_cnt_b = cnt_b_q;

endmodule

// File: tb/tb_axis_packet_router.sv
// Randomized bench for axis_packet_router against a queue-based packet model.
module tb_axis_packet_router;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic [CW-1:0] pkt_cnt_a, pkt_cnt_b;

    axis_packet_router_if #(.DATA_WIDTH(DW)) s0k_if ();
    axis_packet_router_if #(.DATA_WIDTH(DW)) m0a_if ();
    axis_packet_router_if #(.DATA_WIDTH(DW)) m0b_if ();

    axis_packet_router #(.DATA_WIDTH(DW), .SEL_BIT(31), .CNT_WIDTH(CW)) dut (
        .axis_aclk   (clk),
        .axis_areset (rst),
        .s0k_axis    (s0k_if),
        .m0a_axis    (m0a_if),
        .m0b_axis    (m0b_if),
        .pkt_cnt_a   (pkt_cnt_a),
        .pkt_cnt_b   (pkt_cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: beats accepted but not yet delivered, each tagged with
    // the output its packet was steered to when it entered.
    typedef struct {
        logic        dest;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t         q[$];
    logic          in_pkt;
    logic          cur_dest;
    logic [CW-1:0] m_cnt_a, m_cnt_b;
    logic          armed;

    always @(negedge clk) begin
        if (rst) begin
            check_eq("rst_s_tready", 32'(s0k_if.tready), 32'd0);
            check_eq("rst_a_tvalid", 32'(m0a_if.tvalid), 32'd0);
            check_eq("rst_b_tvalid", 32'(m0b_if.tvalid), 32'd0);
            check_eq("rst_cnt_a", 32'(pkt_cnt_a), 32'd0);
            check_eq("rst_cnt_b", 32'(pkt_cnt_b), 32'd0);
            q.delete();
            in_pkt  = 1'b0;
            cur_dest = 1'b0;
            m_cnt_a = '0;
            m_cnt_b = '0;
            armed   = 1'b0;
        end else begin
            logic exp_ready, exp_a_v, exp_b_v, do_pop, do_push, d;
            exp_ready = armed && (q.size() < 2);
            exp_a_v   = (q.size() != 0) && !q[0].dest;
            exp_b_v   = (q.size() != 0) &&  q[0].dest;

            check_eq("cnt_a", 32'(pkt_cnt_a), 32'(m_cnt_a));
            check_eq("cnt_b", 32'(pkt_cnt_b), 32'(m_cnt_b));
            check_eq("s_tready", 32'(s0k_if.tready), 32'(exp_ready));
            check_eq("a_tvalid", 32'(m0a_if.tvalid), 32'(exp_a_v));
            check_eq("b_tvalid", 32'(m0b_if.tvalid), 32'(exp_b_v));
            if (exp_a_v) begin
                check_eq("a_tdata", m0a_if.tdata, q[0].data);
                check_eq("a_tlast", 32'(m0a_if.tlast), 32'(q[0].last));
            end
            if (exp_b_v) begin
                check_eq("b_tdata", m0b_if.tdata, q[0].data);
                check_eq("b_tlast", 32'(m0b_if.tlast), 32'(q[0].last));
            end

            do_pop  = (exp_a_v && m0a_if.tready) || (exp_b_v && m0b_if.tready);
            do_push = exp_ready && s0k_if.tvalid;

            if (do_pop) begin
                if (q[0].last) begin
                    if (q[0].dest) m_cnt_b = m_cnt_b + 1'b1;
                    else           m_cnt_a = m_cnt_a + 1'b1;
                end
                void'(q.pop_front());
            end
            if (do_push) begin
                d = in_pkt ? cur_dest : s0k_if.tdata[31];
                cur_dest = d;
                in_pkt   = !s0k_if.tlast;
                q.push_back('{dest: d, data: s0k_if.tdata, last: s0k_if.tlast});
            end
            armed = 1'b1;
        end
    end

    // Output ready policy: 0 = both ready, 1 = random, 2 = m0a stalled.
    int rdy_mode = 0;

    initial begin
        m0a_if.tready = 1'b0;
        m0b_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: begin m0a_if.tready = 1'b1; m0b_if.tready = 1'b1; end
                1: begin
                    m0a_if.tready = ($urandom_range(0, 3) != 0);
                    m0b_if.tready = ($urandom_range(0, 3) != 0);
                end
                default: begin m0a_if.tready = 1'b0; m0b_if.tready = 1'b1; end
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the beat was taken.
    task automatic drive_beat(input logic [31:0] d, input logic l);
        int n = 0;
        s0k_if.tvalid = 1'b1;
        s0k_if.tdata  = d;
        s0k_if.tlast  = l;
        @(negedge clk);
        while (!s0k_if.tready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) check_eq("in_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        s0k_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] first, input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            drive_beat((i == 0) ? first : $urandom, (i == len - 1));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) check_eq("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s0k_if.tvalid = 1'b0;
        s0k_if.tdata  = '0;
        s0k_if.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ten-beat packet to A, data 1..10.
        rdy_mode = 0;
        for (int i = 1; i <= 10; i++) drive_beat(32'(i), (i == 10));
        wait_idle();
        check_eq("t1_cnt_a", 32'(pkt_cnt_a), 32'd1);
        check_eq("t1_cnt_b", 32'(pkt_cnt_b), 32'd0);

        // Same packet with bit31 set on the first beat only goes entirely to B.
        for (int i = 1; i <= 10; i++) drive_beat((i == 1) ? 32'h8000_0001 : 32'(i), (i == 10));
        wait_idle();
        check_eq("t2_cnt_b", 32'(pkt_cnt_b), 32'd1);

        // Alternating single-beat packets from a clean reset.
        apply_reset();
        drive_beat(32'h0000_0011, 1'b1);
        drive_beat(32'h8000_0012, 1'b1);
        drive_beat(32'h0000_0013, 1'b1);
        drive_beat(32'h8000_0014, 1'b1);
        wait_idle();
        check_eq("t3_cnt_a", 32'(pkt_cnt_a), 32'd2);
        check_eq("t3_cnt_b", 32'(pkt_cnt_b), 32'd2);

        // Stall m0a mid-packet; a following B packet must wait behind it.
        rdy_mode = 2;
        fork
            begin
                send_pkt(32'h0000_0100, 5, 1'b0);
                send_pkt(32'h8000_0200, 3, 1'b0);
            end
            begin
                repeat (6) @(negedge clk);
                check_eq("t4_s_tready_full", 32'(s0k_if.tready), 32'd0);
                check_eq("t4_a_held", 32'(m0a_if.tvalid), 32'd1);
                check_eq("t4_b_blocked", 32'(m0b_if.tvalid), 32'd0);
                @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join
        wait_idle();
        check_eq("t4_cnt_a", 32'(pkt_cnt_a), 32'd3);
        check_eq("t4_cnt_b", 32'(pkt_cnt_b), 32'd3);

        // Reset after beat 4 of a 10-beat packet, then route a fresh B packet.
        for (int i = 0; i < 4; i++) drive_beat(32'h0000_0300 + 32'(i), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_cnt_a", 32'(pkt_cnt_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_pkt(32'h8000_0005, 3, 1'b0);
        wait_idle();
        check_eq("t5_cnt_b", 32'(pkt_cnt_b), 32'd1);
        check_eq("t5_cnt_a", 32'(pkt_cnt_a), 32'd0);

        // Random packets, random gaps, random output backpressure.
        rdy_mode = 1;
        for (int p = 0; p < 150; p++)
            send_pkt($urandom, $urandom_range(1, 6), 1'b1);
        wait_idle();
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Counter wrap on output A.
        apply_reset();
        for (int p = 0; p < 65535; p++) drive_beat($urandom & 32'h7FFF_FFFF, 1'b1);
        wait_idle();
        check_eq("t6_cnt_a_max", 32'(pkt_cnt_a), 32'h0000_FFFF);
        drive_beat(32'h0000_0042, 1'b1);
        wait_idle();
        check_eq("t6_cnt_a_wrap", 32'(pkt_cnt_a), 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_packet_router.md
# axis_packet_router

Single-input, dual-output AXI-Stream packet router: the fan-out counterpart of the `arbiter` block, which merges s0a/s0b into m0k. It accepts one stream on s0k, looks at the first beat of each packet, and steers the whole packet to m0a or m0b. A 2-entry input buffer gives registered backpressure and sustained one-beat-per-cycle throughput. Per-output packet counters are provided for debug and status.

## Interface
Parameters:
- DATA_WIDTH, 32, tdata width of all streams.
- SEL_BIT, 31, index of the first-beat tdata bit that selects the destination: 0 routes to m0a, 1 routes to m0b.
- CNT_WIDTH, 16, width of the packet counters.

Ports:
- axis_aclk  in  1  single clock; all logic is on its rising edge.
- axis_areset  in  1  asynchronous, active-high reset.
- s0k_axis_tdata  in  DATA_WIDTH  input data.
- s0k_axis_tvalid  in  1  input valid.
- s0k_axis_tready  out  1  input ready.
- s0k_axis_tlast  in  1  input end of packet.
- m0a_axis_tdata / tvalid / tlast  out  DATA_WIDTH / 1 / 1  output A.
- m0a_axis_tready  in  1  output A ready.
- m0b_axis_tdata / tvalid / tlast  out  DATA_WIDTH / 1 / 1  output B.
- m0b_axis_tready  in  1  output B ready.
- pkt_cnt_a  out  CNT_WIDTH  count of packets completed on m0a.
- pkt_cnt_b  out  CNT_WIDTH  count of packets completed on m0b.

## Operation
Input buffer:
- 2-entry FIFO holding {tdata, tlast}. count is in 0..2.
- Push on s0k_axis_tvalid && s0k_axis_tready.
- s0k_axis_tready = (count != 2). It is a function of registers only, with no path from m0x_axis_tready.
- Simultaneous push and pop leaves count unchanged.

Head routing (FSM states):
- IDLE: the head beat is a packet start. dest = head.tdata[SEL_BIT].
- ROUTE_A / ROUTE_B: dest is locked to that output.
- The head beat drives only the dest output. tvalid = (count != 0), tdata and tlast come from the head. The non-dest output holds tvalid = 0.
- Pop occurs on dest tvalid && dest tready.
- IDLE to ROUTE_A/B: on a pop with tlast = 0.
- ROUTE_x to IDLE: on a pop with tlast = 1.
- A pop in IDLE with tlast = 1 (single-beat packet) stays in IDLE.
- The packet counter for the dest output increments on any pop with tlast = 1. Counters wrap from all-ones to 0.
- The SEL_BIT of non-first beats is ignored.
- Routing is strictly in order: a packet stalled on one output blocks all following packets, including those for the other output (head-of-line blocking is accepted).
- Data is passed unmodified. tdata and tlast arrive exactly as received.

Reset (asynchronous, takes effect immediately):
- count = 0, FSM = IDLE, both counters = 0.
- m0a_axis_tvalid = m0b_axis_tvalid = 0.
- s0k_axis_tready is forced to 0 while axis_areset is high and becomes 1 in the first cycle after deassertion.
- Reset mid-packet discards buffered beats and any partial packet. The first beat accepted after reset is treated as a packet start.

## Timing
- Latency: a beat accepted at edge N with the FIFO empty shows valid on its output after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while the dest output holds tready = 1.
- s0k_axis_tready falls only after the edge at which count reaches 2. It rises after the edge of the first pop from full.
- Output tdata/tvalid/tlast are held stable while tvalid = 1 and tready = 0, per AXI-Stream.
- Counter updates are visible the cycle after the tlast pop.

## Test plan
- Ten-beat packet (data 1..10, first beat bit31 = 0, tlast on beat 10) with m0a_tready = 1: m0a emits 1..10 back-to-back one cycle after input, tlast on 10. m0b_tvalid stays 0. pkt_cnt_a = 1.
- Same packet with first beat 0x80000001: all 10 beats go to m0b, including beats whose bit31 = 0. pkt_cnt_b = 1.
- Alternating single-beat packets A, B, A, B, all tlast = 1: each beat appears on the correct output in order. Counters end at 2 and 2. Input tready stays 1 throughout.
- Hold m0a_tready = 0 during a packet to A: two beats are buffered, then s0k_tready = 0 and data is held stable. Release tready: beats drain in order with no loss or duplication. A following B packet waits until the A tlast pops.
- Assert axis_areset after beat 4 of a 10-beat packet: tvalid and tready drop immediately and counters read 0. After release, a new packet with first beat 0x80000005 routes to m0b.
- Force pkt_cnt_a to 0xFFFF by sending 65535 single-beat A packets, then send one more: the counter wraps to 0x0000.
